// File: rtl/pattern_det_pkg.sv
// Shared types, default sizes and mask helper for the pattern detector family.
package pattern_det_pkg;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int unsigned DEF_MAX_LEN = 16;
  localparam int unsigned DEF_CNT_W   = 16;

  // Upper bound on pattern width the mask helper can describe.
  localparam int unsigned MASK_W = 64;

  // Mask with the low 'len' bits set; len >= MASK_W yields all ones.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] ones;
    ones = '1;
    return ~(ones << len);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear-then-count when both fire.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over hold, increment applies after clear.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/prog_pattern_det.sv
// Run-time programmable serial bit-pattern detector with saturating match count.
module prog_pattern_det
  import pattern_det_pkg::*;
#(
  parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter  int unsigned CNT_W   = DEF_CNT_W,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               data_valid,
  input  logic               data_in,
  input  logic               cnt_clr,
  output logic               pattern_det,
  output logic [CNT_W-1:0]   det_count,
  output logic               armed
);

  state_e             state_q,   state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q,    hist_d;
  logic [LEN_W-1:0]   fill_q,    fill_d;
  logic               det_q,     det_d;
  logic               err_q,     err_d;
  logic               armed_q,   armed_d;

  logic [MAX_LEN-1:0] mask_c;
  logic [MAX_LEN-1:0] hist_nxt_c;
  logic [LEN_W-1:0]   fill_nxt_c;
  logic               len_ok_c;
  logic               match_c;

  assign mask_c = MAX_LEN'(len_mask(32'(len_q)));

  // Next-state: config load has priority, otherwise shift qualified bits in RUN.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    len_d      = len_q;
    overlap_d  = overlap_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    armed_d    = armed_q;
    det_d      = 1'b0;
    err_d      = 1'b0;
    match_c    = 1'b0;
    len_ok_c   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    hist_nxt_c = {hist_q[MAX_LEN-2:0], data_in};
    fill_nxt_c = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);

    if (cfg_load) begin
      if (len_ok_c) begin
        state_d   = RUN;
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        hist_d    = '0;
        fill_d    = '0;
        armed_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (data_valid && (state_q == RUN)) begin
      // Compare against the history including the bit arriving now.
      match_c = (fill_nxt_c == len_q) &&
                (((hist_nxt_c ^ pattern_q) & mask_c) == '0);
      hist_d  = hist_nxt_c;
      fill_d  = (match_c && !overlap_q) ? '0 : fill_nxt_c;
      det_d   = match_c;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= UNCFG;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      det_q     <= det_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_det_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (det_d),
    .clr   (cnt_clr),
    .count (det_count)
  );

  assign pattern_det = det_q;
  assign cfg_err     = err_q;
  assign armed       = armed_q;

endmodule

// File: tb/tb_prog_pattern_det.sv
// Directed, table-driven checks for prog_pattern_det (MAX_LEN=16, CNT_W=4).
module tb_prog_pattern_det;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LEN_W   = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_err;
  logic               data_valid;
  logic               data_in;
  logic               cnt_clr;
  logic               pattern_det;
  logic [CNT_W-1:0]   det_count;
  logic               armed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic               ld;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic               dv;
    logic               din;
    logic               clr;
    logic               e_det;
    logic [CNT_W-1:0]   e_cnt;
    logic               e_err;
    logic               e_arm;
  } vec_t;

  vec_t tv[$];
  int   ecnt;

  always #5 clk = ~clk;

  prog_pattern_det #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_err     (cfg_err),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .cnt_clr     (cnt_clr),
    .pattern_det (pattern_det),
    .det_count   (det_count),
    .armed       (armed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                     input logic ovl, input logic dv, input logic din, input logic clr,
                     input logic e_det, input logic [CNT_W-1:0] e_cnt, input logic e_err,
                     input logic e_arm);
    vec_t v;
    v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl; v.dv = dv; v.din = din; v.clr = clr;
    v.e_det = e_det; v.e_cnt = e_cnt; v.e_err = e_err; v.e_arm = e_arm;
    tv.push_back(v);
  endtask

  // Serial bit with expected detect; expected count follows the detect.
  task automatic add_bit(input logic din, input logic e_det, input logic e_arm);
    if (e_det && ecnt < 15) ecnt++;
    add(1'b0, '0, '0, 1'b0, 1'b1, din, 1'b0, e_det, CNT_W'(ecnt), 1'b0, e_arm);
  endtask

  task automatic add_idle(input logic e_arm);
    add(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(ecnt), 1'b0, e_arm);
  endtask

  task automatic drive_idle();
    cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    data_valid = 1'b0; data_in = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic e_det, input logic [CNT_W-1:0] e_cnt,
                            input logic e_err, input logic e_arm);
    check({tag, " pattern_det"}, 32'(pattern_det), 32'(e_det));
    check({tag, " det_count"},   32'(det_count),   32'(e_cnt));
    check({tag, " cfg_err"},     32'(cfg_err),     32'(e_err));
    check({tag, " armed"},       32'(armed),       32'(e_arm));
  endtask

  initial begin
    logic [13:0] s14;
    logic [10:0] p11;
    int          idx;

    s14 = 14'b10110110110110;
    p11 = 11'b10110110110;
    ecnt = 0;

    // Unconfigured: 20 bits must be ignored.
    for (int i = 0; i < 20; i++) add_bit(1'(i % 3 != 0), 1'b0, 1'b0);

    // Overlapping 11-bit pattern over 14 bits: hits after bits 11 and 14.
    add(1'b1, MAX_LEN'(p11), 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(ecnt), 1'b0, 1'b1);
    for (int i = 13; i >= 0; i--) begin
      idx = 14 - i;
      add_bit(s14[i], 1'((idx == 11) || (idx == 14)), 1'b1);
    end

    // Non-overlapping reload with counter clear: single hit after bit 11.
    ecnt = 0;
    add(1'b1, MAX_LEN'(p11), 5'd11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CNT_W'(ecnt), 1'b0, 1'b1);
    for (int i = 13; i >= 0; i--) begin
      idx = 14 - i;
      add_bit(s14[i], 1'(idx == 11), 1'b1);
    end

    // Rejected loads (len 0, len MAX_LEN+1) keep the prior config.
    add(1'b1, 16'hFFFF, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(ecnt), 1'b1, 1'b1);
    add_idle(1'b1);
    add(1'b1, 16'hFFFF, 5'd17, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(ecnt), 1'b1, 1'b1);
    add_idle(1'b1);
    for (int i = 10; i >= 0; i--) add_bit(p11[i], 1'(i == 0), 1'b1);

    // 1011 with 3-cycle bubbles; clear lands with the completing bit.
    add(1'b1, 16'h000B, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(ecnt), 1'b0, 1'b1);
    add_bit(1'b1, 1'b0, 1'b1);
    repeat (3) add_idle(1'b1);
    add_bit(1'b0, 1'b0, 1'b1);
    repeat (3) add_idle(1'b1);
    add_bit(1'b1, 1'b0, 1'b1);
    repeat (3) add_idle(1'b1);
    ecnt = 1;
    add(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, CNT_W'(ecnt), 1'b0, 1'b1);
    add_idle(1'b1);

    // len=1 pattern '1'; load drops a concurrent valid bit; count saturates at 15.
    ecnt = 0;
    add(1'b1, 16'h0001, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, CNT_W'(ecnt), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) add_bit(1'b1, 1'b1, 1'b1);

    // Reset and check cleared state.
    drive_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;

    foreach (tv[i]) begin
      cfg_load = tv[i].ld; cfg_pattern = tv[i].pat; cfg_len = tv[i].len;
      cfg_overlap = tv[i].ovl; data_valid = tv[i].dv; data_in = tv[i].din;
      cnt_clr = tv[i].clr;
      @(posedge clk);
      #1;
      check_outs($sformatf("v%0d", i), tv[i].e_det, tv[i].e_cnt, tv[i].e_err, tv[i].e_arm);
    end

    // Reset mid-stream while a match would fire.
    data_valid = 1'b1; data_in = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outs("midrst", 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;

    // Back in UNCFG: ones are ignored.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outs($sformatf("uncfg%0d", i), 1'b0, '0, 1'b0, 1'b0);
    end

    // Reconfigure and detect again from a clean counter.
    cfg_load = 1'b1; cfg_pattern = 16'h0001; cfg_len = 5'd1; cfg_overlap = 1'b1;
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outs("reload", 1'b0, '0, 1'b0, 1'b1);
    cfg_load = 1'b0; data_valid = 1'b1; data_in = 1'b1;
    @(posedge clk);
    #1;
    check_outs("redet", 1'b1, 4'd1, 1'b0, 1'b1);
    drive_idle();
    @(posedge clk);
    #1;
    check_outs("pulse_end", 1'b0, 4'd1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
